// File: rtl/cpu_pkg.sv
// Shared core definitions: pipeline-control FSM states, PC mux selects and register constants.
package cpu_pkg;

  typedef enum logic [0:0] {
    RUN        = 1'b0,
    REDIR_HOLD = 1'b1
  } pipe_state_e;

  localparam logic       PC_SEL_SEQ   = 1'b0;
  localparam logic       PC_SEL_REDIR = 1'b1;
  localparam logic [4:0] REG_X0       = 5'd0;

  // A load in EX feeding a source register of the instruction in ID; x0 never creates a dependency.
  function automatic logic load_use_hazard(
    input logic       ex_is_load,
    input logic [4:0] ex_rd,
    input logic       use_rs1,
    input logic [4:0] rs1,
    input logic       use_rs2,
    input logic [4:0] rs2
  );
    return ex_is_load && (ex_rd != REG_X0) &&
           ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Stall and flush event counters for the pipeline control unit; both wrap at 2^CNT_W.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_i) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_i) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline control: stage enables, bubble flushes and PC mux select, with a redirect
// hold while a fetch is in flight. Optional counters are built with PIPE_CTRL_PERF_EN defined.
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      id_rs1_addr_i,
  input  logic [4:0]      id_rs2_addr_i,
  input  logic            id_use_rs1_i,
  input  logic            id_use_rs2_i,
  input  logic            ex_is_load_i,
  input  logic [4:0]      ex_rd_addr_i,
  input  logic            ex_redirect_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            im_stall_i,
  input  logic            dm_stall_i,
  output logic            pc_we_o,
  output logic            pc_sel_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            if_id_we_o,
  output logic            id_ex_we_o,
  output logic            ex_mem_we_o,
  output logic            mem_wb_we_o,
  output logic            if_id_flush_o,
  output logic            id_ex_flush_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt_o,
  output logic [CNT_W-1:0] perf_flush_cnt_o
`endif
);

  pipe_state_e     state_q, state_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            lu;
  logic            hold_stalled;

  assign lu = load_use_hazard(ex_is_load_i, ex_rd_addr_i, id_use_rs1_i, id_rs1_addr_i,
                              id_use_rs2_i, id_rs2_addr_i);
  assign hold_stalled = im_stall_i || dm_stall_i;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    state_d       = state_q;
    tgt_d         = tgt_q;
    pc_we_o       = 1'b1;
    pc_sel_o      = PC_SEL_SEQ;
    redirect_pc_o = ex_target_i;
    if_id_we_o    = 1'b1;
    id_ex_we_o    = 1'b1;
    ex_mem_we_o   = 1'b1;
    mem_wb_we_o   = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;

    unique case (state_q)
      RUN: begin
        if (dm_stall_i) begin
          // Whole pipe freezes; redirect and hazard inputs are simply re-presented next cycle.
          pc_we_o     = 1'b0;
          if_id_we_o  = 1'b0;
          id_ex_we_o  = 1'b0;
          ex_mem_we_o = 1'b0;
          mem_wb_we_o = 1'b0;
        end else if (ex_redirect_i && im_stall_i) begin
          // Fetch bus is busy: park the target and replay it once the fetch returns.
          state_d       = REDIR_HOLD;
          tgt_d         = ex_target_i;
          pc_we_o       = 1'b0;
          if_id_we_o    = 1'b0;
          id_ex_flush_o = 1'b1;
        end else if (ex_redirect_i) begin
          pc_sel_o      = PC_SEL_REDIR;
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end else if (lu) begin
          pc_we_o       = 1'b0;
          if_id_we_o    = 1'b0;
          id_ex_flush_o = 1'b1;
        end else if (im_stall_i) begin
          pc_we_o       = 1'b0;
          if_id_flush_o = 1'b1;
        end
      end

      REDIR_HOLD: begin
        pc_sel_o      = PC_SEL_REDIR;
        redirect_pc_o = tgt_q;
        id_ex_flush_o = 1'b1;
        id_ex_we_o    = !dm_stall_i;
        ex_mem_we_o   = !dm_stall_i;
        mem_wb_we_o   = !dm_stall_i;
        if (hold_stalled) begin
          pc_we_o    = 1'b0;
          if_id_we_o = 1'b0;
        end else begin
          // The word that finally returns is from the wrong path, so it is dropped.
          if_id_flush_o = 1'b1;
          state_d       = RUN;
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (!pc_we_o),
    .flush_i     (if_id_flush_o || id_ex_flush_o),
    .stall_cnt_o (perf_stall_cnt_o),
    .flush_cnt_o (perf_flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic against a rule-level reference model. Define PIPE_CTRL_PERF_EN to cover counters.
module tb_pipe_ctrl;
  import cpu_pkg::*;

  localparam int XLEN = 32;

  typedef struct {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            use1;
    logic            use2;
    logic            load;
    logic [4:0]      rd;
    logic            redir;
    logic [XLEN-1:0] target;
    logic            im;
    logic            dm;
  } in_t;

  // ctrl packing: {pc_we, pc_sel, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush}
  typedef struct {
    in_t             in;
    logic [7:0]      ctrl;
    logic [XLEN-1:0] pc;
  } vec_t;

  localparam logic [7:0] C_NORM   = 8'b1011_1100;
  localparam logic [7:0] C_LU     = 8'b0001_1101;
  localparam logic [7:0] C_REDIR  = 8'b1111_1111;
  localparam logic [7:0] C_PARK   = 8'b0001_1101;
  localparam logic [7:0] C_HOLDIM = 8'b0101_1101;
  localparam logic [7:0] C_HOLDDM = 8'b0100_0001;
  localparam logic [7:0] C_FREEZE = 8'b0000_0000;
  localparam logic [7:0] C_IMST   = 8'b0011_1110;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4:0]      id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic            id_use_rs1, id_use_rs2, ex_is_load, ex_redirect, im_stall, dm_stall;
  logic [XLEN-1:0] ex_target, redirect_pc;
  logic            pc_we, pc_sel, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]     perf_stall_cnt, perf_flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  bit              m_hold;
  logic [XLEN-1:0] m_tgt;
  logic [31:0]     m_stall_cnt, m_flush_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_rs1_addr_i (id_rs1_addr),
    .id_rs2_addr_i (id_rs2_addr),
    .id_use_rs1_i  (id_use_rs1),
    .id_use_rs2_i  (id_use_rs2),
    .ex_is_load_i  (ex_is_load),
    .ex_rd_addr_i  (ex_rd_addr),
    .ex_redirect_i (ex_redirect),
    .ex_target_i   (ex_target),
    .im_stall_i    (im_stall),
    .dm_stall_i    (dm_stall),
    .pc_we_o       (pc_we),
    .pc_sel_o      (pc_sel),
    .redirect_pc_o (redirect_pc),
    .if_id_we_o    (if_id_we),
    .id_ex_we_o    (id_ex_we),
    .ex_mem_we_o   (ex_mem_we),
    .mem_wb_we_o   (mem_wb_we),
    .if_id_flush_o (if_id_flush),
    .id_ex_flush_o (id_ex_flush)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cnt_o (perf_stall_cnt),
    .perf_flush_cnt_o (perf_flush_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic in_t mk(input logic [4:0] rs1, input logic use1, input logic [4:0] rs2,
                             input logic use2, input logic load, input logic [4:0] rd,
                             input logic redir, input logic [XLEN-1:0] target,
                             input logic im, input logic dm);
    in_t v;
    v.rs1 = rs1; v.use1 = use1; v.rs2 = rs2; v.use2 = use2; v.load = load; v.rd = rd;
    v.redir = redir; v.target = target; v.im = im; v.dm = dm;
    return v;
  endfunction

  // Reference model: the priority rules applied directly to one cycle of inputs.
  function automatic void model(input in_t i, input bit hold, input logic [XLEN-1:0] tgt,
                                output logic [7:0] ctrl, output logic [XLEN-1:0] pc,
                                output bit nhold, output logic [XLEN-1:0] ntgt);
    bit lu;
    lu = i.load && (i.rd != 0) &&
         ((i.use1 && (i.rs1 == i.rd)) || (i.use2 && (i.rs2 == i.rd)));
    nhold = hold;
    ntgt  = tgt;
    if (hold) begin
      pc = tgt;
      if (i.im || i.dm) ctrl = {1'b0, 1'b1, 1'b0, !i.dm, !i.dm, !i.dm, 1'b0, 1'b1};
      else begin
        ctrl  = C_REDIR;
        nhold = 0;
      end
    end else begin
      pc = i.target;
      if (i.dm)                ctrl = C_FREEZE;
      else if (i.redir && i.im) begin
        ctrl  = C_PARK;
        nhold = 1;
        ntgt  = i.target;
      end
      else if (i.redir)        ctrl = C_REDIR;
      else if (lu)             ctrl = C_LU;
      else if (i.im)           ctrl = C_IMST;
      else                     ctrl = C_NORM;
    end
  endfunction

  task automatic drive(input in_t v);
    id_rs1_addr = v.rs1; id_use_rs1 = v.use1; id_rs2_addr = v.rs2; id_use_rs2 = v.use2;
    ex_is_load  = v.load; ex_rd_addr = v.rd; ex_redirect = v.redir; ex_target = v.target;
    im_stall    = v.im;   dm_stall   = v.dm;
  endtask

  function automatic logic [7:0] dut_ctrl();
    return {pc_we, pc_sel, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush};
  endfunction

  // One clock cycle starting at a negedge: drive, compare mid-cycle, advance model at posedge.
  task automatic cycle(input in_t v, input logic [7:0] exp_ctrl, input logic [XLEN-1:0] exp_pc,
                       input string name);
    logic [7:0]      c;
    logic [XLEN-1:0] p, nt;
    bit              nh;
    drive(v);
    #1;
    check({name, " ctrl"}, {24'd0, dut_ctrl()}, {24'd0, exp_ctrl});
    if (exp_ctrl[6]) check({name, " redirect_pc"}, redirect_pc, exp_pc);
    model(v, m_hold, m_tgt, c, p, nh, nt);
    @(posedge clk);
    m_hold = nh;
    m_tgt  = nt;
    if (!c[7]) m_stall_cnt++;
    if (c[1] || c[0]) m_flush_cnt++;
    @(negedge clk);
  endtask

  task automatic model_cycle(input in_t v, input string name);
    logic [7:0]      c;
    logic [XLEN-1:0] p, nt;
    bit              nh;
    model(v, m_hold, m_tgt, c, p, nh, nt);
    cycle(v, c, p, name);
  endtask

  task automatic check_perf(input string name);
`ifdef PIPE_CTRL_PERF_EN
    check({name, " stall_cnt"}, perf_stall_cnt, m_stall_cnt);
    check({name, " flush_cnt"}, perf_flush_cnt, m_flush_cnt);
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  vec_t vecs[20];
  in_t  idle, v;

  initial begin
    idle = mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    vecs[0]  = '{mk(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 32'h0, 1'b0, 1'b0), C_NORM, 32'h0};
    vecs[1]  = '{mk(5'd5, 1'b1, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0, 32'h0, 1'b0, 1'b0), C_LU, 32'h0};
    vecs[2]  = '{idle, C_NORM, 32'h0};
    vecs[3]  = '{mk(5'd0, 1'b1, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0), C_NORM, 32'h0};
    vecs[4]  = '{mk(5'd9, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 32'h0, 1'b0, 1'b0), C_LU, 32'h0};
    vecs[5]  = '{mk(5'd9, 1'b0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 32'h0, 1'b0, 1'b0), C_NORM, 32'h0};
    vecs[6]  = '{mk(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 32'h100, 1'b0, 1'b0), C_REDIR, 32'h100};
    vecs[7]  = '{idle, C_NORM, 32'h0};
    vecs[8]  = '{mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h200, 1'b1, 1'b0), C_PARK, 32'h0};
    vecs[9]  = '{mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h999, 1'b1, 1'b0), C_HOLDIM, 32'h200};
    vecs[10] = '{mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0), C_HOLDIM, 32'h200};
    vecs[11] = '{mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h444, 1'b0, 1'b0), C_REDIR, 32'h200};
    vecs[12] = '{idle, C_NORM, 32'h0};
    vecs[13] = '{mk(5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 32'h300, 1'b0, 1'b1), C_FREEZE, 32'h0};
    vecs[14] = '{mk(5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 32'h300, 1'b1, 1'b1), C_FREEZE, 32'h0};
    vecs[15] = '{mk(5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 32'h300, 1'b0, 1'b0), C_REDIR, 32'h300};
    vecs[16] = '{mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0), C_IMST, 32'h0};
    vecs[17] = '{mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h580, 1'b1, 1'b0), C_PARK, 32'h0};
    vecs[18] = '{mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1), C_HOLDDM, 32'h580};
    vecs[19] = '{idle, C_REDIR, 32'h580};

    rst_n = 1'b0;
    drive(idle);
    m_hold = 0; m_tgt = '0; m_stall_cnt = '0; m_flush_cnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset ctrl", {24'd0, dut_ctrl()}, {24'd0, C_NORM});
    check_perf("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Counter scenario: one load-use bubble and one plain redirect.
    cycle(idle, C_NORM, 32'h0, "perf idle0");
    cycle(vecs[1].in, C_LU, 32'h0, "perf lu");
    cycle(idle, C_NORM, 32'h0, "perf idle1");
    cycle(vecs[6].in, C_REDIR, 32'h100, "perf redirect");
    drive(idle);
    #1;
`ifdef PIPE_CTRL_PERF_EN
    check("perf stall_cnt==1", perf_stall_cnt, 32'd1);
    check("perf flush_cnt==2", perf_flush_cnt, 32'd2);
`endif
    @(negedge clk);

    for (int i = 0; i < 20; i++) cycle(vecs[i].in, vecs[i].ctrl, vecs[i].pc, $sformatf("vec%0d", i));
    check_perf("after table");

    // Asynchronous reset while parked in REDIR_HOLD.
    cycle(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 32'hABC, 1'b1, 1'b0), C_PARK, 32'h0, "park abc");
    drive(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0));
    #1;
    check("hold before reset ctrl", {24'd0, dut_ctrl()}, {24'd0, C_HOLDIM});
    check("hold before reset pc", redirect_pc, 32'hABC);
    rst_n = 1'b0;
    #1;
    check("reset mid-hold ctrl", {24'd0, dut_ctrl()}, {24'd0, C_IMST});
    check("reset mid-hold tgt_q", dut.tgt_q, 32'h0);
    m_hold = 0; m_tgt = '0; m_stall_cnt = '0; m_flush_cnt = '0;
    check_perf("reset mid-hold");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0), C_IMST, 32'h0, "after reset");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      v.rs1    = 5'($urandom_range(0, 7));
      v.rs2    = 5'($urandom_range(0, 7));
      v.use1   = 1'($urandom_range(0, 1));
      v.use2   = 1'($urandom_range(0, 1));
      v.load   = ($urandom_range(0, 2) == 0);
      v.rd     = 5'($urandom_range(0, 7));
      v.redir  = ($urandom_range(0, 4) == 0);
      v.target = $urandom() & 32'hFFFF_FFFC;
      v.im     = ($urandom_range(0, 3) == 0);
      v.dm     = ($urandom_range(0, 5) == 0);
      model_cycle(v, $sformatf("rand%0d", n));
      if (n % 100 == 99) check_perf($sformatf("rand%0d", n));
    end
    check_perf("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage RV32I core: it sequences the IF/ID/EX/MEM/WB pipeline registers and the PC mux.
- Generates per-stage write-enable and flush strobes from four sources: load-use hazards detected in ID, branch/jump redirects resolved in EX, instruction-memory wait, and data-memory wait.
- A small FSM holds a redirect when it arrives while an instruction fetch is still in flight, then replays it.
- It sits beside the decoder and immediate generator, consuming decoded register fields and EX-stage resolution results.

## Interface
Parameters:
- XLEN, 32, PC/target width
- CNT_W, 32, width of each performance counter (only with PIPE_CTRL_PERF_EN)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1_addr_i  in  5  rs1 field of instruction in ID
- id_rs2_addr_i  in  5  rs2 field of instruction in ID
- id_use_rs1_i  in  1  ID instruction reads rs1
- id_use_rs2_i  in  1  ID instruction reads rs2
- ex_is_load_i  in  1  EX holds a load
- ex_rd_addr_i  in  5  EX destination register
- ex_redirect_i  in  1  EX taken branch, JAL or JALR
- ex_target_i  in  XLEN  EX redirect target
- im_stall_i  in  1  fetch not complete this cycle
- dm_stall_i  in  1  data access not complete this cycle
- pc_we_o  out  1  PC register update enable
- pc_sel_o  out  1  0 = PC+4, 1 = redirect_pc_o
- redirect_pc_o  out  XLEN  redirect target to PC mux
- if_id_we_o, id_ex_we_o, ex_mem_we_o, mem_wb_we_o  out  1 each  pipeline register enables
- if_id_flush_o, id_ex_flush_o  out  1 each  load a NOP bubble
- perf_stall_cnt_o, perf_flush_cnt_o  out  CNT_W each  counters (PIPE_CTRL_PERF_EN only)

## Operation
States: RUN, REDIR_HOLD.

Registered state: FSM state, redirect target register `tgt_q`, counters. Reset values are RUN, tgt_q = 0, counters = 0. All other outputs are combinational from state and inputs.

Load-use hazard: `lu = ex_is_load_i && ex_rd_addr_i != 0 && ((id_use_rs1_i && id_rs1_addr_i == ex_rd_addr_i) || (id_use_rs2_i && id_rs2_addr_i == ex_rd_addr_i))`.

In RUN, the first matching rule applies:
1. dm_stall_i: all *_we_o = 0, no flush, pc_sel_o = 0. Everything freezes, including a pending redirect or lu; these are re-evaluated next cycle.
2. ex_redirect_i && im_stall_i: latch ex_target_i into tgt_q and go to REDIR_HOLD. Outputs:
   - pc_we_o = 0, if_id_we_o = 0
   - id_ex_flush_o = 1 (wrong-path ID instruction squashed)
   - ex_mem_we_o = mem_wb_we_o = 1
3. ex_redirect_i: pc_sel_o = 1, redirect_pc_o = ex_target_i, pc_we_o = 1, if_id_flush_o = 1, id_ex_flush_o = 1, all we = 1. lu is ignored because the ID instruction is squashed.
4. lu: pc_we_o = 0, if_id_we_o = 0, id_ex_flush_o = 1, downstream we = 1.
5. im_stall_i: pc_we_o = 0, if_id_flush_o = 1, downstream we = 1.
6. Otherwise all we = 1, no flush, pc_sel_o = 0.

In REDIR_HOLD:
- redirect_pc_o = tgt_q, pc_sel_o = 1.
- While im_stall_i || dm_stall_i: pc_we_o = 0 and if_id_we_o = 0.
- Otherwise: pc_we_o = 1 and if_id_flush_o = 1 (the returning wrong-path word is dropped); go to RUN.
- ID/EX receives a bubble every cycle in REDIR_HOLD (id_ex_flush_o = 1). EX/MEM and MEM/WB follow dm_stall_i.
- ex_redirect_i is ignored: EX holds a bubble.

Flush takes precedence over we in the pipeline registers. Asserting rst_n low mid-operation returns the block to RUN and discards tgt_q.

## Timing
- Decision latency is zero cycles: strobes are valid in the same cycle as the inputs and sampled at the next rising clk.
- A redirect with no stall costs 2 bubbles. A redirect during a fetch wait costs 2 bubbles plus the remaining im_stall cycles.
- A load-use hazard costs exactly one bubble, provided ex_is_load_i drops once the load advances.
- dm_stall_i may be held indefinitely; no state changes while it is asserted.

## Configuration
PIPE_CTRL_PERF_EN, when defined:
- perf_stall_cnt_o increments each cycle pc_we_o == 0.
- perf_flush_cnt_o increments each cycle if_id_flush_o || id_ex_flush_o.
- Both counters wrap at 2^CNT_W and reset to 0.

When not defined, the counter ports and registers are absent.

## Structure
- The shared package cpu_pkg holds:
  - the `pipe_state_e` enum {RUN, REDIR_HOLD}
  - `PC_SEL_SEQ`/`PC_SEL_REDIR` constants
  - `REG_X0 = 5'd0`
- One sub-module, pipe_perf_cnt, holds the two counters and is instantiated only under PIPE_CTRL_PERF_EN.

## Test plan
- Load-use: load x5 in EX, `add x6,x5,x1` in ID (rs1 = 5), no stalls → one cycle of pc_we_o = 0, if_id_we_o = 0, id_ex_flush_o = 1, then normal flow. Same with ex_rd_addr_i = 0 → no stall.
- Plain redirect: ex_redirect_i = 1, ex_target_i = 0x0000_0100 → same cycle pc_sel_o = 1, redirect_pc_o = 0x100, both flushes = 1; next cycle normal.
- Redirect during fetch wait: ex_redirect_i with target 0x200 and im_stall_i = 1 for 3 cycles → REDIR_HOLD with redirect_pc_o = 0x200 and pc_we_o = 0 for 3 cycles; on the 4th cycle pc_we_o = 1 and if_id_flush_o = 1; then RUN.
- Data stall priority: dm_stall_i = 1 together with ex_redirect_i and lu for 2 cycles → all we = 0 and no flush; after release, the redirect is applied (rule 3).
- Reset mid-hold: drop rst_n in REDIR_HOLD → state RUN, tgt_q = 0, counters = 0 immediately, without waiting for clk.
- PIPE_CTRL_PERF_EN defined: 1 load-use stall plus 1 plain redirect → perf_stall_cnt_o = 1, perf_flush_cnt_o = 2.
